// File: rtl/valu_issue.sv
// Issue/writeback controller that owns the vector register file and drives the combinational valu.
// Define VALU_ISSUE_FAST_READ_EN to drop the READ state and latch operands at the accept edge.
module valu_issue #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ELEMENTS   = 8,
    parameter int unsigned NUM_VREGS  = 32,
    localparam int unsigned VEC_W     = DATA_WIDTH * ELEMENTS,
    localparam int unsigned IDX_W     = $clog2(NUM_VREGS)
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             instr_valid_in,
    output logic             instr_ready_o,
    input  logic [3:0]       instr_op_in,
    input  logic [IDX_W-1:0] instr_vd_in,
    input  logic [IDX_W-1:0] instr_vs1_in,
    input  logic [IDX_W-1:0] instr_vs2_in,
    output logic [3:0]       valu_op_o,
    output logic [VEC_W-1:0] vrs1_data_o,
    output logic [VEC_W-1:0] vrs2_data_o,
    input  logic [VEC_W-1:0] valu_res_in,
    output logic             done_o,
    output logic [IDX_W-1:0] done_vd_o,
    input  logic             vwr_en_in,
    input  logic [IDX_W-1:0] vwr_addr_in,
    input  logic [VEC_W-1:0] vwr_data_in,
    input  logic [IDX_W-1:0] vrd_addr_in,
    output logic [VEC_W-1:0] vrd_data_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             accept, ld_opnd, ld_res, wb_en;
    logic [IDX_W-1:0] vd_q;
    logic [IDX_W-1:0] rd_idx1, rd_idx2;
    logic [3:0]       rd_op;
    logic [3:0]       op_q;
    logic [VEC_W-1:0] opnd1_q, opnd2_q, res_q;
    logic             done_q, ready_q;
    logic [IDX_W-1:0] done_vd_q;
    logic [VEC_W-1:0] vreg_q [NUM_VREGS];

    // Next-state and load-enable decode
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        ld_opnd = 1'b0;
        ld_res  = 1'b0;
        wb_en   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (instr_valid_in) begin
                    accept = 1'b1;
`ifdef VALU_ISSUE_FAST_READ_EN
                    ld_opnd = 1'b1;
                    state_d = S_EXEC;
`else
                    state_d = S_READ;
`endif
                end
            end
            S_READ: begin
                ld_opnd = 1'b1;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                ld_res  = 1'b1;
                state_d = S_WB;
            end
            S_WB: begin
                wb_en   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef VALU_ISSUE_FAST_READ_EN
    assign rd_idx1 = instr_vs1_in;
    assign rd_idx2 = instr_vs2_in;
    assign rd_op   = instr_op_in;
`else
    logic [IDX_W-1:0] vs1_q, vs2_q;
    logic [3:0]       iop_q;

    // Source indices and opcode held until READ
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            vs1_q <= '0;
            vs2_q <= '0;
            iop_q <= '0;
        end else if (accept) begin
            vs1_q <= instr_vs1_in;
            vs2_q <= instr_vs2_in;
            iop_q <= instr_op_in;
        end
    end

    assign rd_idx1 = vs1_q;
    assign rd_idx2 = vs2_q;
    assign rd_op   = iop_q;
`endif

    // Control, operand and result registers; outputs decoded from state_d so they are registered
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q   <= S_IDLE;
            vd_q      <= '0;
            op_q      <= '0;
            opnd1_q   <= '0;
            opnd2_q   <= '0;
            res_q     <= '0;
            done_q    <= 1'b0;
            done_vd_q <= '0;
            ready_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == S_IDLE);
            done_q  <= (state_d == S_WB);
            if (accept) begin
                vd_q <= instr_vd_in;
            end
            if (state_d == S_WB) begin
                done_vd_q <= vd_q;
            end
            if (ld_opnd) begin
                op_q    <= rd_op;
                opnd1_q <= vreg_q[rd_idx1];
                opnd2_q <= vreg_q[rd_idx2];
            end
            if (ld_res) begin
                res_q <= valu_res_in;
            end
        end
    end

    // Register file: writeback is ordered after the host write so it wins on an index collision
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < int'(NUM_VREGS); i++) begin
                vreg_q[i] <= '0;
            end
        end else begin
            if (vwr_en_in) begin
                vreg_q[vwr_addr_in] <= vwr_data_in;
            end
            if (wb_en) begin
                vreg_q[vd_q] <= res_q;
            end
        end
    end

    assign instr_ready_o = ready_q;
    assign done_o        = done_q;
    assign done_vd_o     = done_vd_q;
    assign valu_op_o     = op_q;
    assign vrs1_data_o   = opnd1_q;
    assign vrs2_data_o   = opnd2_q;
    assign vrd_data_o    = vreg_q[vrd_addr_in];

endmodule

// File: tb/tb_valu_issue.sv
// Scoreboard bench for valu_issue: directed instructions, an adder model of valu, and a
// writeback monitor that checks each done pulse against queued expectations.
module tb_valu_issue;

    localparam int unsigned DW = 32;
    localparam int unsigned EL = 8;
    localparam int unsigned VW = DW * EL;
`ifdef VALU_ISSUE_FAST_READ_EN
    localparam int DONE_LAT = 1;
`else
    localparam int DONE_LAT = 2;
`endif
    localparam int PERIOD = DONE_LAT + 2;

    logic          clk_in = 1'b0;
    logic          rst_n_in;
    logic          instr_valid_in;
    logic          instr_ready_o;
    logic [3:0]    instr_op_in;
    logic [4:0]    instr_vd_in, instr_vs1_in, instr_vs2_in;
    logic [3:0]    valu_op_o;
    logic [VW-1:0] vrs1_data_o, vrs2_data_o, valu_res_in;
    logic          done_o;
    logic [4:0]    done_vd_o;
    logic          vwr_en_in;
    logic [4:0]    vwr_addr_in;
    logic [VW-1:0] vwr_data_in;
    logic [4:0]    vrd_addr_in;
    logic [VW-1:0] vrd_data_o;

    valu_issue dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .instr_valid_in (instr_valid_in),
        .instr_ready_o  (instr_ready_o),
        .instr_op_in    (instr_op_in),
        .instr_vd_in    (instr_vd_in),
        .instr_vs1_in   (instr_vs1_in),
        .instr_vs2_in   (instr_vs2_in),
        .valu_op_o      (valu_op_o),
        .vrs1_data_o    (vrs1_data_o),
        .vrs2_data_o    (vrs2_data_o),
        .valu_res_in    (valu_res_in),
        .done_o         (done_o),
        .done_vd_o      (done_vd_o),
        .vwr_en_in      (vwr_en_in),
        .vwr_addr_in    (vwr_addr_in),
        .vwr_data_in    (vwr_data_in),
        .vrd_addr_in    (vrd_addr_in),
        .vrd_data_o     (vrd_data_o)
    );

    always #5 clk_in = ~clk_in;

    // valu stand-in: element-wise add
    always_comb begin
        valu_res_in = '0;
        for (int i = 0; i < int'(EL); i++) begin
            valu_res_in[i*DW +: DW] = vrs1_data_o[i*DW +: DW] + vrs2_data_o[i*DW +: DW];
        end
    end

    typedef struct {
        logic [4:0]    vd;
        logic [3:0]    op;
        logic [VW-1:0] a;
        logic [VW-1:0] b;
    } exp_t;

    exp_t exp_q[$];
    int   acc_q[$];
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    function automatic logic [VW-1:0] mk(input int base, input int step);
        logic [VW-1:0] v;
        v = '0;
        for (int i = 0; i < int'(EL); i++) begin
            v[i*DW +: DW] = DW'(base + step * i);
        end
        return v;
    endfunction

    always @(posedge clk_in) begin
        cyc <= cyc + 1;
        if (rst_n_in && instr_valid_in && instr_ready_o) begin
            acc_q.push_back(cyc);
        end
    end

    // Writeback monitor: every done pulse must match the oldest queued instruction
    always @(negedge clk_in) begin
        if (rst_n_in && done_o) begin
            if (exp_q.size() == 0 || acc_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done_vd=%0d with nothing pending", done_vd_o);
            end else begin
                exp_t e;
                int   a;
                e = exp_q.pop_front();
                a = acc_q.pop_front();
                chk("done_cycle", VW'(cyc), VW'(a + DONE_LAT + 1));
                chk("done_vd", VW'(done_vd_o), VW'(e.vd));
                chk("wb_op", VW'(valu_op_o), VW'(e.op));
                chk("wb_vrs1", vrs1_data_o, e.a);
                chk("wb_vrs2", vrs2_data_o, e.b);
            end
        end
    end

    task automatic expect_wb(input logic [4:0] vd, input logic [3:0] op,
                             input logic [VW-1:0] a, input logic [VW-1:0] b);
        exp_t e;
        e.vd = vd; e.op = op; e.a = a; e.b = b;
        exp_q.push_back(e);
    endtask

    task automatic host_wr(input logic [4:0] addr, input logic [VW-1:0] data);
        vwr_en_in   = 1'b1;
        vwr_addr_in = addr;
        vwr_data_in = data;
        @(negedge clk_in);
        vwr_en_in   = 1'b0;
    endtask

    task automatic rd_chk(input string nm, input logic [4:0] addr, input logic [VW-1:0] req);
        vrd_addr_in = addr;
        #1;
        chk(nm, vrd_data_o, req);
    endtask

    task automatic issue(input logic [3:0] op, input logic [4:0] vd,
                         input logic [4:0] vs1, input logic [4:0] vs2);
        int n = 0;
        while (!instr_ready_o && n < 20) begin
            @(negedge clk_in);
            n++;
        end
        instr_valid_in = 1'b1;
        instr_op_in    = op;
        instr_vd_in    = vd;
        instr_vs1_in   = vs1;
        instr_vs2_in   = vs2;
        @(negedge clk_in);
        instr_valid_in = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(instr_ready_o && exp_q.size() == 0) && n < 30) begin
            @(negedge clk_in);
            n++;
        end
        if (n >= 30) begin
            tests++;
            fails++;
            $display("FAIL idle_timeout: got pending=%0d required 0", exp_q.size());
        end
        @(negedge clk_in);
    endtask

    initial begin
        int a1, a2, n;
        rst_n_in = 1'b0; instr_valid_in = 1'b0; instr_op_in = '0;
        instr_vd_in = '0; instr_vs1_in = '0; instr_vs2_in = '0;
        vwr_en_in = 1'b0; vwr_addr_in = '0; vwr_data_in = '0; vrd_addr_in = '0;
        repeat (2) @(negedge clk_in);
        rst_n_in = 1'b1;
        @(negedge clk_in);

        // Basic add
        host_wr(5'd1, mk(1, 1));
        host_wr(5'd2, mk(1, 1));
        rd_chk("load_v1", 5'd1, mk(1, 1));
        expect_wb(5'd3, 4'd0, mk(1, 1), mk(1, 1));
        issue(4'd0, 5'd3, 5'd1, 5'd2);
`ifndef VALU_ISSUE_FAST_READ_EN
        @(negedge clk_in);
`endif
        chk("exec_vrs1", vrs1_data_o, mk(1, 1));
        chk("exec_done_low", VW'(done_o), VW'(0));
        wait_idle();
        rd_chk("add_v3", 5'd3, mk(2, 2));

        // Back-to-back with read-after-write on v3
        expect_wb(5'd3, 4'd0, mk(1, 1), mk(1, 1));
        expect_wb(5'd4, 4'd0, mk(2, 2), mk(2, 2));
        a1 = cyc;
        instr_valid_in = 1'b1; instr_op_in = 4'd0;
        instr_vd_in = 5'd3; instr_vs1_in = 5'd1; instr_vs2_in = 5'd2;
        @(negedge clk_in);
        instr_vd_in = 5'd4; instr_vs1_in = 5'd3; instr_vs2_in = 5'd3;
        n = 0;
        while (!instr_ready_o && n < 20) begin
            @(negedge clk_in);
            n++;
        end
        a2 = cyc;
        @(negedge clk_in);
        instr_valid_in = 1'b0;
        chk("b2b_gap", VW'(a2 - a1), VW'(PERIOD));
        wait_idle();
        rd_chk("raw_v4", 5'd4, mk(4, 4));

        // Host write colliding with writeback to the same index
        expect_wb(5'd3, 4'd0, mk(1, 1), mk(1, 1));
        issue(4'd0, 5'd3, 5'd1, 5'd2);
        n = 0;
        while (!done_o && n < 20) begin
            @(negedge clk_in);
            n++;
        end
        host_wr(5'd3, mk(9, 1));
        wait_idle();
        rd_chk("collide_v3", 5'd3, mk(2, 2));

        // Host write to a different index on the writeback edge
        host_wr(5'd3, '0);
        expect_wb(5'd3, 4'd0, mk(1, 1), mk(1, 1));
        issue(4'd0, 5'd3, 5'd1, 5'd2);
        n = 0;
        while (!done_o && n < 20) begin
            @(negedge clk_in);
            n++;
        end
        host_wr(5'd5, mk(9, 1));
        wait_idle();
        rd_chk("both_v5", 5'd5, mk(9, 1));
        rd_chk("both_v3", 5'd3, mk(2, 2));

        // In-place alias vd == vs1
        host_wr(5'd2, mk(10, 0));
        expect_wb(5'd1, 4'd0, mk(1, 1), mk(10, 0));
        issue(4'd0, 5'd1, 5'd1, 5'd2);
        wait_idle();
        rd_chk("alias_v1", 5'd1, mk(11, 1));

        // Abort: reset during EXEC, also the mid-run reset check
        host_wr(5'd0, mk(3, 1));
        host_wr(5'd7, mk(4, 1));
        host_wr(5'd31, mk(5, 1));
        issue(4'd5, 5'd6, 5'd1, 5'd2);
`ifndef VALU_ISSUE_FAST_READ_EN
        @(negedge clk_in);
`endif
        rst_n_in = 1'b0;
        #1;
        chk("rst_done", VW'(done_o), VW'(0));
        chk("rst_ready", VW'(instr_ready_o), VW'(1));
        chk("rst_op", VW'(valu_op_o), VW'(0));
        chk("rst_vrs1", vrs1_data_o, '0);
        chk("rst_vrs2", vrs2_data_o, '0);
        acc_q.delete();
        @(negedge clk_in);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        repeat (6) @(negedge clk_in);
        chk("abort_ready", VW'(instr_ready_o), VW'(1));
        rd_chk("abort_v6", 5'd6, '0);
        rd_chk("rst_v0", 5'd0, '0);
        rd_chk("rst_v7", 5'd7, '0);
        rd_chk("rst_v31", 5'd31, '0);
        rd_chk("rst_v1", 5'd1, '0);
        chk("sb_drained", VW'(exp_q.size()), VW'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, required finish before 100000");
        $fatal(1, "watchdog");
    end

endmodule
